// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: op codes, ALU command encoding
// and the sequencer state enum.
package alu_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_NOT  = 4'h0,
        OP_AND  = 4'h1,
        OP_OR   = 4'h2,
        OP_XOR  = 4'h3,
        OP_NAND = 4'h4,
        OP_NOR  = 4'h5,
        OP_XNOR = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_ROL  = 4'h9,
        OP_ROR  = 4'hA,
        OP_ADD  = 4'hB,
        OP_SUB  = 4'hC
    } op_e;

    localparam logic [3:0] OP_MAX = 4'hC;

    typedef enum logic [1:0] {
        ACT_IDLE   = 2'd0,
        ACT_LOAD_A = 2'd1,
        ACT_LOAD_B = 2'd2,
        ACT_EXEC   = 2'd3
    } act_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        CAPTURE,
        RESPOND
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Drives an external registered ALU through load A / load B / execute,
// skipping operand loads the ALU already holds, and returns one response.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_error,
    output logic [1:0] alu_act,
    output logic [7:0] alu_data,
    input  logic [7:0] alu_result
);

    state_e     state;
    state_e     next_state;
    logic [3:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       need_b_q;
    logic       a_valid;
    logic       b_valid;
    logic [7:0] shadow_a;
    logic [7:0] shadow_b;

    logic       need_a;
    logic       need_b;
    logic [3:0] cur_op;
    logic [7:0] cur_a;
    logic [7:0] cur_b;

    assign req_ready = (state == IDLE);

    // Skip decisions compare the incoming request against what the ALU holds.
    assign need_a = !(a_valid && (req_a == shadow_a));
    assign need_b = !((req_op == OP_NOT) || (b_valid && (req_b == shadow_b)));

    assign cur_op = (state == IDLE) ? req_op : op_q;
    assign cur_a  = (state == IDLE) ? req_a  : a_q;
    assign cur_b  = (state == IDLE) ? req_b  : b_q;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!op_is_legal(req_op)) next_state = RESPOND;
                    else if (need_a)          next_state = LOAD_A;
                    else if (need_b)          next_state = LOAD_B;
                    else                      next_state = EXEC;
                end
            end
            LOAD_A:  next_state = need_b_q ? LOAD_B : EXEC;
            LOAD_B:  next_state = EXEC;
            EXEC:    next_state = CAPTURE;
            CAPTURE: next_state = RESPOND;
            RESPOND: if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the request
    // and shadow registers are deliberately left out of reset since the valid
    // flags and FSM state qualify every use of them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            a_valid    <= 1'b0;
            b_valid    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 8'h00;
            rsp_error  <= 1'b0;
            alu_act    <= ACT_IDLE;
            alu_data   <= 8'h00;
        end else begin
            state <= next_state;

            // ALU command is registered from the state being entered.
            case (next_state)
                LOAD_A: begin
                    alu_act  <= ACT_LOAD_A;
                    alu_data <= cur_a;
                end
                LOAD_B: begin
                    alu_act  <= ACT_LOAD_B;
                    alu_data <= cur_b;
                end
                EXEC: begin
                    alu_act  <= ACT_EXEC;
                    alu_data <= {4'h0, cur_op};
                end
                default: begin
                    alu_act  <= ACT_IDLE;
                    alu_data <= 8'h00;
                end
            endcase

            if (state == IDLE && req_valid) begin
                op_q     <= req_op;
                a_q      <= req_a;
                b_q      <= req_b;
                need_b_q <= need_b;
            end

            if (state == LOAD_A) begin
                a_valid  <= 1'b1;
                shadow_a <= a_q;
            end
            if (state == LOAD_B) begin
                b_valid  <= 1'b1;
                shadow_b <= b_q;
            end

            if (state == IDLE && next_state == RESPOND) begin
                rsp_valid  <= 1'b1;
                rsp_result <= 8'h00;
                rsp_error  <= 1'b1;
            end
            if (state == CAPTURE) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_error  <= 1'b0;
            end
            if (state == RESPOND && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural registered ALU and a
// scoreboard queue of expected responses.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_error;
    logic [1:0] alu_act;
    logic [7:0] alu_data;
    logic [7:0] alu_result;

    typedef struct {
        logic [7:0] result;
        logic       error;
        int         cycle;
    } exp_t;

    exp_t sb[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    alu_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .alu_act    (alu_act),
        .alu_data   (alu_data),
        .alu_result (alu_result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU: operand registers plus a registered result.
    logic [7:0] alu_a_reg = 8'h00;
    logic [7:0] alu_b_reg = 8'h00;
    logic [7:0] alu_res   = 8'h00;
    assign alu_result = alu_res;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, b, input logic [3:0] op);
        case (op)
            4'h0: return ~a;
            4'h1: return a & b;
            4'h2: return a | b;
            4'h3: return a ^ b;
            4'h4: return ~(a & b);
            4'h5: return ~(a | b);
            4'h6: return ~(a ^ b);
            4'h7: return a << 1;
            4'h8: return a >> 1;
            4'h9: return {a[6:0], a[7]};
            4'hA: return {a[0], a[7:1]};
            4'hB: return a + b;
            4'hC: return a - b;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clock) begin
        case (alu_act)
            2'd1: alu_a_reg <= alu_data;
            2'd2: alu_b_reg <= alu_data;
            2'd3: alu_res   <= alu_fn(alu_a_reg, alu_b_reg, alu_data[3:0]);
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one request, follow the ALU commands cycle by cycle, then consume
    // the response after holding rsp_ready low for 'hold' cycles.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input bit la, input bit lb, input bit illegal,
                        input logic [7:0] exp_res, input int hold);
        logic [1:0] acts  [8];
        logic [7:0] datas [8];
        int   n;
        bit   seen;
        exp_t e;
        exp_t got;
        n = 1;
        if (!illegal) begin
            if (la) begin acts[n] = 2'd1; datas[n] = a; n++; end
            if (lb) begin acts[n] = 2'd2; datas[n] = b; n++; end
            acts[n] = 2'd3; datas[n] = {4'h0, op}; n++;
            acts[n] = 2'd0; datas[n] = 8'h00;      n++;
        end
        e.result = exp_res;
        e.error  = illegal;
        e.cycle  = n;
        sb.push_back(e);

        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        @(negedge clock);
        req_valid = 1'b0;

        seen = 1'b0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                got  = sb.pop_front();
                check("rsp_cycle",  c, got.cycle);
                check("rsp_result", {24'd0, rsp_result}, {24'd0, got.result});
                check("rsp_error",  {31'd0, rsp_error},  {31'd0, got.error});
                check("act_in_respond", {30'd0, alu_act}, 32'd0);
            end else begin
                if (c < n) begin
                    check("alu_act",  {30'd0, alu_act},  {30'd0, acts[c]});
                    check("alu_data", {24'd0, alu_data}, {24'd0, datas[c]});
                end
                @(negedge clock);
            end
        end
        if (!seen) begin
            assert_count++;
            fail_count++;
            $error("FAIL rsp_timeout: observed no rsp_valid expected rsp_valid in cycle %0d", n);
            void'(sb.pop_front());
        end

        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_valid",  {31'd0, rsp_valid},  32'd1);
            check("hold_result", {24'd0, rsp_result}, {24'd0, exp_res});
            check("hold_ready",  {31'd0, req_ready},  32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("rsp_cleared",   {31'd0, rsp_valid}, 32'd0);
        check("idle_after_rsp", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        check("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
        check("rst_rsp_error",  {31'd0, rsp_error},  32'd0);
        check("rst_alu_act",    {30'd0, alu_act},    32'd0);
        check("rst_alu_data",   {24'd0, alu_data},   32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Full sequence, then fully cached, illegal, cached again.
        send(8'h12, 8'h34, 4'hB, 1'b1, 1'b1, 1'b0, 8'h46, 0);
        send(8'h12, 8'h34, 4'hC, 1'b0, 1'b0, 1'b0, 8'hDE, 0);
        send(8'h12, 8'h34, 4'hD, 1'b0, 1'b0, 1'b1, 8'h00, 0);
        send(8'h12, 8'h34, 4'hC, 1'b0, 1'b0, 1'b0, 8'hDE, 0);
        send(8'h77, 8'h34, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 0);
        // NOT with a fresh A never loads B.
        send(8'h0F, 8'h55, 4'h0, 1'b1, 1'b0, 1'b0, 8'hF0, 0);
        // Cached A, new B, response held off for three cycles.
        send(8'h0F, 8'h55, 4'h1, 1'b0, 1'b1, 1'b0, 8'h05, 3);

        // Reset during EXEC abandons the request and clears the cache.
        check("pre_reset_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_a     = 8'h0F;
        req_b     = 8'h55;
        req_op    = 4'hB;
        @(negedge clock);
        req_valid = 1'b0;
        check("exec_before_reset", {30'd0, alu_act}, 32'd3);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_alu_act",   {30'd0, alu_act},   32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready",     {31'd0, req_ready}, 32'd1);
        check("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        send(8'h0F, 8'h55, 4'hB, 1'b1, 1'b1, 1'b0, 8'h64, 0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have: clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock).
REQ-003 SHALL have: req_valid  input  1  request offered.
REQ-004 SHALL have: req_ready  output  1  sequencer can accept a request.
REQ-005 SHALL have: req_op  input  4  ALU op code (0x0..0xC legal).
REQ-006 SHALL have: req_a  input  8  operand A; req_b  input  8  operand B.
REQ-007 SHALL have: rsp_valid  output  1  response held.
REQ-008 SHALL have: rsp_ready  input  1  consumer takes response.
REQ-009 SHALL have: rsp_result  output  8  ALU result; rsp_error  output  1  illegal op flag.
REQ-010 SHALL have: alu_act  output  2  ALU command (0 idle, 1 load A, 2 load B, 3 execute).
REQ-011 SHALL have: alu_data  output  8  ALU data bus; alu_result  input  8  ALU registered result.

Function
REQ-012 SHALL be the initiator of the ALU act/data protocol: load A, load B, execute with data[3:0]=op, one command per cycle.
REQ-013 SHALL use states IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, RESPOND.
REQ-014 SHALL assert req_ready only in IDLE; accept when req_valid & req_ready, latching req_op/req_a/req_b at that edge.
REQ-015 SHALL drive alu_act=1/alu_data=A in LOAD_A, alu_act=2/alu_data=B in LOAD_B, alu_act=3/alu_data={4'h0,op} in EXEC; alu_act=0, alu_data=0x00 in all other states.
REQ-016 SHALL sample alu_result into rsp_result at the end of CAPTURE (ALU result is valid the cycle after EXEC).
REQ-017 SHALL keep cache flags a_valid/b_valid plus shadow copies of last A/B written to the ALU; update on each LOAD_A/LOAD_B.
REQ-018 SHALL skip LOAD_A when a_valid and latched A equals shadow A; skip LOAD_B when op==0x0 (NOT) or (b_valid and latched B equals shadow B).
REQ-019 SHALL, counting cycle 1 as the first cycle after acceptance, occupy one cycle per needed load, then EXEC, CAPTURE, RESPOND: full sequence puts rsp_valid high in cycle 5, no loads in cycle 3.
REQ-020 SHALL treat op > 0xC as illegal: no nonzero alu_act, go directly to RESPOND (cycle 1) with rsp_result=0x00, rsp_error=1, cache unchanged.
REQ-021 SHALL hold rsp_valid, rsp_result, rsp_error stable in RESPOND until rsp_ready=1; return to IDLE on that edge; no request accepted in the same cycle.
REQ-022 SHALL set rsp_error=0 for all legal ops.

Reset
REQ-023 SHALL on reset=0 at a rising edge enter IDLE, clear a_valid/b_valid, and set rsp_valid=0, rsp_result=0x00, rsp_error=0, alu_act=0, alu_data=0x00; req_ready=1 after release.
REQ-024 SHALL abandon any in-flight request when reset occurs mid-sequence; no response is produced for it.

Structure
REQ-025 SHALL take op codes (0x0..0xC), the act encoding, OP_MAX=4'hC, and the state enum from shared package alu_sequencer_pkg.
REQ-026 SHALL be a single module with no sub-module; the ALU is instantiated alongside it (bench/top), not inside.

Verification
REQ-027 SHALL cover: after reset, A=0x12 B=0x34 op=0xB -> alu_act 1,2,3 in cycles 1-3, rsp_valid cycle 5, result 0x46, error 0.
REQ-028 SHALL cover: next request A=0x12 B=0x34 op=0xC -> both loads skipped, alu_act=3 in cycle 1, rsp_valid cycle 3, result 0xDE.
REQ-029 SHALL cover: A=0x0F op=0x0 (fresh A) -> only LOAD_A then EXEC, rsp_valid cycle 4, result 0xF0.
REQ-030 SHALL cover: op=0xD -> alu_act stays 0, rsp_valid cycle 1, result 0x00, error 1; following repeat of REQ-028 request still skips loads.
REQ-031 SHALL cover: rsp_ready held low 3 cycles in RESPOND -> rsp_valid/rsp_result stable, req_ready 0; IDLE one cycle after rsp_ready=1.
REQ-032 SHALL cover: reset=0 during EXEC -> next cycle alu_act=0, rsp_valid=0, req_ready=1 after release; repeating the prior request performs full LOAD_A and LOAD_B.
